// File: rtl/gray_pkg.sv
// Shared pointer widths and Gray/binary conversion helpers for the async FIFO controllers.
package gray_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned FN_W   = 32;

  // Callers zero-extend into FN_W and truncate the result; zero upper bits keep both conversions width-agnostic.
  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync_2ff.sv
// Two-stage clock-domain-crossing synchronizer with asynchronous active-low reset.
module gray_sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] rq1_q;
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] rq2_q;
  logic [W-1:0] rq1_d;
  logic [W-1:0] rq2_d;

  always_comb begin
    rq1_d = d;
    rq2_d = rq1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= rq1_d;
      rq2_q <= rq2_d;
    end
  end

  assign q = rq2_q;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of an async FIFO: write pointer, exported Gray pointer,
// synchronized read pointer, and full/level/overflow status.
module async_fifo_wr_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned N = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [N:0]   rd_ptr_gray,
  output logic         wr_accept,
  output logic [N-1:0] wr_addr,
  output logic [N:0]   wr_ptr_gray,
  output logic         full,
  output logic [N:0]   level,
  output logic         overflow
);

  localparam int unsigned PW = N + 1;
  // Full when the write pointer equals the read pointer with its top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (N - 1);

  logic [PW-1:0] wr_ptr_bin_q, wr_ptr_bin_d;
  logic [PW-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic          full_q, full_d;
  logic [PW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [PW-1:0] rq2;
  logic          accept;

  gray_sync_2ff #(.W(PW)) u_rd_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rd_ptr_gray),
    .q     (rq2)
  );

  always_comb begin
    accept        = wr_en & ~full_q;
    wr_ptr_bin_d  = wr_ptr_bin_q + PW'(accept);
    wr_ptr_gray_d = PW'(bin2gray(FN_W'(wr_ptr_bin_d)));
    full_d        = (wr_ptr_gray_d == (rq2 ^ FULL_MASK));
    level_d       = wr_ptr_bin_d - PW'(gray2bin(FN_W'(rq2)));
    overflow_d    = wr_en & full_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      full_q        <= 1'b0;
      level_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      full_q        <= full_d;
      level_q       <= level_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_accept   = accept;
  assign wr_addr     = wr_ptr_bin_q[N-1:0];
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_q;
  assign level       = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed bench for async_fifo_wr_ctrl with N=4: vector table plus hand sequences.
module tb_async_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] rd_ptr_gray = '0;
  logic       wr_accept;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic [4:0] level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  async_fifo_wr_ctrl #(.N(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_accept   (wr_accept),
    .wr_addr     (wr_addr),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .level       (level),
    .overflow    (overflow)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  typedef struct {
    logic       wr_en;
    logic [4:0] rd_gray;
    logic       exp_acc;
    logic [3:0] exp_addr;
    logic [4:0] exp_gray;
    logic       exp_full;
    logic [4:0] exp_level;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [4:0] g5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic vec_t mk(input logic we, input logic [4:0] rg, input logic acc,
                              input logic [3:0] ad, input logic [4:0] gr, input logic fu,
                              input logic [4:0] lv, input logic ov);
    vec_t v;
    v.wr_en = we; v.rd_gray = rg; v.exp_acc = acc; v.exp_addr = ad;
    v.exp_gray = gr; v.exp_full = fu; v.exp_level = lv; v.exp_ovf = ov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive at negedge, check combinational outputs, then check registered outputs after the edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    wr_en       = v.wr_en;
    rd_ptr_gray = v.rd_gray;
    #1;
    chk($sformatf("v%0d wr_accept", idx), 32'(wr_accept), 32'(v.exp_acc));
    chk($sformatf("v%0d wr_addr", idx), 32'(wr_addr), 32'(v.exp_addr));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d wr_ptr_gray", idx), 32'(wr_ptr_gray), 32'(v.exp_gray));
    chk($sformatf("v%0d full", idx), 32'(full), 32'(v.exp_full));
    chk($sformatf("v%0d level", idx), 32'(level), 32'(v.exp_level));
    chk($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.exp_ovf));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " wr_accept"}, 32'(wr_accept), 32'd0);
    chk({tag, " wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, " wr_ptr_gray"}, 32'(wr_ptr_gray), 32'd0);
    chk({tag, " full"}, 32'(full), 32'd0);
    chk({tag, " level"}, 32'(level), 32'd0);
    chk({tag, " overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int b;
    logic [4:0] prev_gray;
    logic saw_wrap;
    logic we;

    // Fill: 16 back-to-back writes with the read pointer at 0.
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(1'b1, 5'd0, 1'b1, 4'(i), g5(i + 1), (i == 15), 5'(i + 1), 1'b0));
    // Overflow: three rejected writes, then an idle cycle.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 5'd16, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 5'd16, 1'b0));
    // Drain one entry: full drops on the third edge after the read pointer moves.
    vecs.push_back(mk(1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b1, 5'd16, 1'b0));
    vecs.push_back(mk(1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b1, 5'd16, 1'b0));
    vecs.push_back(mk(1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b0, 5'd15, 1'b0));
    vecs.push_back(mk(1'b1, 5'b00001, 1'b1, 4'd0, 5'b11001, 1'b1, 5'd16, 1'b0));

    // Reset with the clock stopped.
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_noclk");
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1 wr_en = 1'b1;
    #1 chk("post_reset accept_hi", 32'(wr_accept), 32'd1);
    wr_en = 1'b0;
    #1 chk("post_reset accept_lo", 32'(wr_accept), 32'd0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Read side catches up to 13 while write pointer sits at 17.
    @(negedge clk);
    wr_en = 1'b0;
    rd_ptr_gray = g5(13);
    repeat (3) @(posedge clk);
    #1;
    chk("catchup full", 32'(full), 32'd0);
    chk("catchup level", 32'(level), 32'd4);

    // Wrap: writes on alternate cycles, read pointer trails the write pointer by 4.
    b = 17;
    saw_wrap = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      we = (c % 2 == 0);
      wr_en = we;
      rd_ptr_gray = g5(b - 4);
      prev_gray = wr_ptr_gray;
      #1 chk("wrap accept", 32'(wr_accept), 32'(we));
      @(posedge clk);
      #1;
      if (we) b++;
      chk("wrap gray", 32'(wr_ptr_gray), 32'(g5(b)));
      chk("wrap onebit", 32'($countones(prev_gray ^ wr_ptr_gray)), 32'(we));
      chk("wrap full", 32'(full), 32'd0);
      chk("wrap level_le6", 32'(level <= 5'd6), 32'd1);
      if (prev_gray == 5'b10000 && wr_ptr_gray == 5'b00000) saw_wrap = 1'b1;
    end
    chk("wrap seen", 32'(saw_wrap), 32'd1);

    // Reset mid-fill.
    @(negedge clk);
    wr_en = 1'b0;
    rd_ptr_gray = '0;
    rst_n = 1'b0;
    #1 chk_zero("reset_a");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++)
      apply(mk(1'b1, 5'd0, 1'b1, 4'(i), g5(i + 1), 1'b0, 5'(i + 1), 1'b0), 100 + i);
    chk("midfill addr", 32'(wr_addr), 32'd7);
    wr_en = 1'b0;
    rst_n = 1'b0;
    #1 chk_zero("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1'b1, 5'd0, 1'b1, 4'd0, 5'b00001, 1'b0, 5'd1, 1'b0), 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
